// File: rtl/hero_write_rx.sv
// hero_write_rx: receive end of the hero write bus.
// Collects VALID*/DONE beats from the bag-side transmitter into a beat FIFO
// and presents them on a valid/ready stream with last/err flags. The bus
// cannot be stalled. On FIFO overflow or an over-length burst the
// transaction is cut short with an error terminator, and a sticky flag is set.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   hero_cycle_type   0=IDLE 1=VALID 2=DONE 3=illegal
//   hero_wdat/tag     beat data / another_type_reference
//   hero_clk_en       beat qualifier; the bus is ignored when low
//   m_valid/m_ready   output stream handshake
//   m_data/tag/last/err  output beat fields
//   txn_cnt           count of last-flagged entries pushed (wraps)
//   ovf_err/len_err/proto_err  sticky errors, cleared by err_clr (set wins)
module hero_write_rx #(
    parameter int DATA_W    = 36,
    parameter int TAG_W     = 5,
    parameter int DEPTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        hero_cycle_type,
    input  logic [DATA_W-1:0] hero_wdat,
    input  logic [TAG_W-1:0]  hero_tag,
    input  logic              hero_clk_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [TAG_W-1:0]  m_tag,
    output logic              m_last,
    output logic              m_err,
    output logic [15:0]       txn_cnt,
    output logic              ovf_err,
    output logic              len_err,
    output logic              proto_err,
    input  logic              err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(MAX_BEATS);
    localparam int EW = DATA_W + TAG_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DROP} state_t;

    state_t            state, nxt_state;
    logic [BW-1:0]     beat_cnt, nxt_beat;
    logic [TAG_W-1:0]  tag_q;
    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;

    logic is_valid, is_done, is_bad, room, pop, too_long;
    logic push, push_last, push_err, cap_tag, set_ovf, set_len;
    logic [TAG_W-1:0] push_tag;

    assign is_valid = hero_clk_en && (hero_cycle_type == 2'd1);
    assign is_done  = hero_clk_en && (hero_cycle_type == 2'd2);
    assign is_bad   = hero_clk_en && (hero_cycle_type == 2'd3);
    // Last slot is held back for an error terminator; no credit for a same-cycle pop.
    assign room     = count < CW'(DEPTH - 1);
    assign pop      = m_valid && m_ready;
    assign too_long = is_valid && (beat_cnt == BW'(MAX_BEATS - 1));

    always_comb begin
        nxt_state = state;
        nxt_beat  = beat_cnt;
        push      = 1'b0;
        push_last = 1'b0;
        push_err  = 1'b0;
        push_tag  = tag_q;
        cap_tag   = 1'b0;
        set_ovf   = 1'b0;
        set_len   = 1'b0;
        case (state)
            S_IDLE: begin
                push_tag = hero_tag;
                if (is_valid) begin
                    if (room) begin
                        push      = 1'b1;
                        cap_tag   = 1'b1;
                        nxt_beat  = BW'(1);
                        nxt_state = S_BURST;
                    end else begin
                        set_ovf   = 1'b1;
                        nxt_state = S_DROP;
                    end
                end else if (is_done) begin
                    if (room) begin
                        push      = 1'b1;
                        push_last = 1'b1;
                    end else begin
                        set_ovf   = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (is_valid || is_done) begin
                    push = 1'b1;
                    if (!room || too_long) begin
                        // Terminator: offending beat's data, closes the transaction as errored.
                        push_last = 1'b1;
                        push_err  = 1'b1;
                        set_ovf   = !room;
                        set_len   = too_long;
                        nxt_state = is_valid ? S_DROP : S_IDLE;
                    end else if (is_valid) begin
                        nxt_beat  = beat_cnt + BW'(1);
                    end else begin
                        push_last = 1'b1;
                        nxt_state = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (is_done) nxt_state = S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            tag_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            txn_cnt   <= '0;
            ovf_err   <= 1'b0;
            len_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state    <= nxt_state;
            beat_cnt <= nxt_beat;
            if (cap_tag) tag_q <= hero_tag;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (push_last) txn_cnt <= txn_cnt + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            // Clear first so a same-cycle set wins.
            if (err_clr) begin
                ovf_err   <= 1'b0;
                len_err   <= 1'b0;
                proto_err <= 1'b0;
            end
            if (set_ovf) ovf_err   <= 1'b1;
            if (set_len) len_err   <= 1'b1;
            if (is_bad)  proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {hero_wdat, push_tag, push_last, push_err};
    end

    // Head entry is read straight from storage; zeroed when empty so stale
    // contents never show after reset.
    assign m_valid = (count != '0);
    assign {m_data, m_tag, m_last, m_err} = m_valid ? mem[rd_ptr] : '0;

endmodule
